repl_policy_unit: RTL

Parametrised replacement-policy and statistics engine for the set-associative L2 cache controller. Tracks per-set recency under three selectable policies (RANDOM, PLRU, LRU), answers victim-way requests on a miss, and keeps saturating hit/miss counters. It sits beside the L2 tag array. Compared with the earlier fixed-geometry policy logic, it adds arbitrary ways/sets, run-time policy switching without state loss, and clearable counters.

---
 rtl/cache_pkg.sv | 16 +
 rtl/repl_lfsr.sv | 24 ++
 rtl/repl_policy_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared constants for the L2 replacement-policy logic: policy encodings,
// debug switches and the victim LFSR seed/taps.
package cache_pkg;

    localparam logic [1:0] RANDOM = 2'd0;
    localparam logic [1:0] PLRU   = 2'd1;
    localparam logic [1:0] LRU    = 2'd2;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/repl_lfsr.sv
// 16-bit Fibonacci LFSR used as the RANDOM-policy victim source.
module repl_lfsr
    import cache_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    output logic [15:0] o_lfsr
);

    logic w_fb;

    assign w_fb = ^(o_lfsr & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_lfsr <= SEED;
        else if (i_en)
            o_lfsr <= {w_fb, o_lfsr[15:1]};
    end

endmodule

// File: rtl/repl_policy_unit.sv
// Per-set LRU ages and PLRU trees, victim selection under a run-time policy,
// and saturating hit/miss counters for the L2 controller.
module repl_policy_unit
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 256,
    parameter int CNT_W = 32,
    localparam int WW   = $clog2(WAYS),
    localparam int SW   = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       policy,
    input  logic             access_vld,
    input  logic [SW-1:0]    access_set,
    input  logic             access_hit,
    input  logic [WW-1:0]    access_way,
    input  logic             victim_req,
    input  logic [SW-1:0]    victim_set,
    output logic             victim_vld,
    output logic [WW-1:0]    victim_way,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    logic [WAYS-1:0][WW-1:0] r_age  [SETS];
    logic [WAYS-2:0]         r_plru [SETS];

    logic [15:0]             w_lfsr;
    logic [WAYS-1:0][WW-1:0] w_age_cur, w_age_nxt;
    logic [WAYS-2:0]         w_plru_nxt;
    logic [WW-1:0]           w_vict;
    logic                    w_unused_lfsr;

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WW-1:0]   w);
        int n;
        logic b;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            b    = w[WW-1-l];
            t[n] = ~b;
            n    = 2*n + 1 + int'(b);
        end
        return t;
    endfunction

    function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] t);
        int n;
        logic b;
        logic [WW-1:0] w;
        n = 0;
        w = '0;
        for (int l = 0; l < WW; l++) begin
            b          = t[n];
            w[WW-1-l]  = b;
            n          = 2*n + 1 + int'(b);
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] lru_victim(input logic [WAYS-1:0][WW-1:0] a);
        logic [WW-1:0] w;
        w = '0;
        for (int v = 0; v < WAYS; v++)
            if (a[v] == WW'(WAYS-1))
                w = WW'(v);
        return w;
    endfunction

    repl_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (1'b1),
        .o_lfsr (w_lfsr)
    );

    assign w_unused_lfsr = &{1'b0, w_lfsr[15:WW]};

    // Both recency structures are touched on every access so a policy switch
    // finds them already up to date.
    always_comb begin
        w_age_cur = r_age[access_set];
        w_age_nxt = w_age_cur;
        for (int v = 0; v < WAYS; v++)
            if (w_age_cur[v] < w_age_cur[access_way])
                w_age_nxt[v] = WW'(w_age_cur[v] + 1'b1);
        w_age_nxt[access_way] = '0;
        w_plru_nxt = plru_touch(r_plru[access_set], access_way);
    end

    // Victim reads pre-update state; a same-cycle access lands at the same edge.
    always_comb begin
        case (policy)
            RANDOM:  w_vict = w_lfsr[WW-1:0];
            PLRU:    w_vict = plru_victim(r_plru[victim_set]);
            default: w_vict = lru_victim(r_age[victim_set]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= WW'(w);
                r_plru[s] <= '0;
            end
        end else if (access_vld) begin
            r_age[access_set]  <= w_age_nxt;
            r_plru[access_set] <= w_plru_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_vld <= 1'b0;
            victim_way <= '0;
        end else begin
            victim_vld <= victim_req;
            if (victim_req)
                victim_way <= w_vict;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (clr_stats) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (access_vld) begin
            if (access_hit) begin
                if (~&hit_count)
                    hit_count <= hit_count + 1'b1;
            end else begin
                if (~&miss_count)
                    miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule
